// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters share one slot, with a registered one-hot grant and its encoded index.
// Optional HOLD_TIMEOUT_EN macro bounds each grant to MAX_HOLD cycles while others are waiting.
module rr_arbiter8 #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDW      = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam int unsigned HCW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic           gnt_valid_nxt;

  logic [N-1:0]   req_other;
  logic [IDW-1:0] after_owner;
  logic [IDW-1:0] idle_win;
  logic [IDW-1:0] rot_win;

  // First set bit of r at or after start, scanning upward with wrap.
  function automatic logic [IDW-1:0] rr_search(input logic [N-1:0]   r,
                                               input logic [IDW-1:0] start);
    logic [IDW-1:0] win;
    int unsigned    j;
    win = start;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      j = (int'(start) + i) % N;
      if (r[j]) win = IDW'(j);
    end
    return win;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
    return N'(1) << idx;
  endfunction

  assign req_other   = req & ~gnt;
  assign after_owner = IDW'((int'(gnt_id) + 1) % N);
  assign idle_win    = rr_search(req, ptr);
  assign rot_win     = rr_search(req_other, after_owner);

`ifdef HOLD_TIMEOUT_EN
  logic [HCW-1:0] hold_cnt;
  logic [HCW-1:0] hold_cnt_nxt;
  logic           hold_expired;

  assign hold_expired = (hold_cnt == HCW'(MAX_HOLD - 1));
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
    end
  end

`ifdef HOLD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_cnt_nxt;
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
`ifdef HOLD_TIMEOUT_EN
    hold_cnt_nxt  = hold_cnt;
`endif

    case (state)
      IDLE: begin
        if (en && (|req)) begin
          state_nxt     = GRANT;
          gnt_nxt       = onehot(idle_win);
          gnt_id_nxt    = idle_win;
          gnt_valid_nxt = 1'b1;
`ifdef HOLD_TIMEOUT_EN
          hold_cnt_nxt  = '0;
`endif
        end
      end

      GRANT: begin
        if (req[gnt_id]) begin
`ifdef HOLD_TIMEOUT_EN
          // Owner still busy: rotate away only once its hold budget is used up.
          if (hold_expired) begin
            hold_cnt_nxt = '0;
            if (en && (|req_other)) begin
              ptr_nxt    = after_owner;
              gnt_nxt    = onehot(rot_win);
              gnt_id_nxt = rot_win;
            end
          end else begin
            hold_cnt_nxt = hold_cnt + HCW'(1);
          end
`endif
        end else begin
          // Release: hand over on the same edge when possible, else go idle.
          ptr_nxt = after_owner;
          if (en && (|req_other)) begin
            gnt_nxt    = onehot(rot_win);
            gnt_id_nxt = rot_win;
          end else begin
            state_nxt     = IDLE;
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
          end
`ifdef HOLD_TIMEOUT_EN
          hold_cnt_nxt = '0;
`endif
        end
      end

      default: begin
        state_nxt     = IDLE;
        gnt_nxt       = '0;
        gnt_valid_nxt = 1'b0;
      end
    endcase
  end

`ifndef SYNTHESIS
  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_valid  : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
  a_id     : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid |-> gnt[gnt_id]);
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized and directed bench for rr_arbiter8 against a behavioural round-robin model.
// Define HOLD_TIMEOUT_EN for both bench and RTL to exercise the hold timeout.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  int n_checks;
  int n_pass;

  // Model: owner index (-1 when idle), last granted id, search pointer, hold count.
  int m_owner;
  int m_id;
  int m_ptr;
  int m_hold;

  rr_arbiter8 #(.N(8), .IDW(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int search(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++)
      if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_id    = 0;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    logic [7:0] others;
    if (m_owner < 0) begin
      if (e && r != 8'h00) begin
        m_owner = search(r, m_ptr);
        m_id    = m_owner;
        m_hold  = 0;
      end
    end else if (r[m_owner]) begin
      others = r & ~(8'h01 << m_owner);
`ifdef HOLD_TIMEOUT_EN
      if (m_hold == MAX_HOLD - 1) begin
        m_hold = 0;
        if (e && others != 8'h00) begin
          m_ptr   = (m_owner + 1) % 8;
          m_owner = search(others, m_ptr);
          m_id    = m_owner;
        end
      end else begin
        m_hold++;
      end
`else
      if (others != 8'h00) m_hold = m_hold;
`endif
    end else begin
      m_ptr = (m_owner + 1) % 8;
      if (e && r != 8'h00) begin
        m_owner = search(r, m_ptr);
        m_id    = m_owner;
        m_hold  = 0;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(m_id));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    check({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'(1));
    check({tag, ".valid_or"}, 32'(gnt_valid), 32'(|gnt));
    if (gnt_valid) check({tag, ".id_match"}, 32'(gnt[gnt_id]), 32'(1));
  endtask

  // Drive one cycle of inputs at the falling edge, then compare at the next falling edge.
  task automatic cycle(input string tag, input logic [7:0] r, input logic e);
    req = r;
    en  = e;
    model_step(r, e);
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    logic [7:0] r;
    logic       e;
    int         exp_id;

    n_checks = 0;
    n_pass   = 0;
    model_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;

    // Reset held with all requests pending.
    repeat (3) @(negedge clk);
    check("rst.gnt", 32'(gnt), 32'h0);
    check("rst.gnt_id", 32'(gnt_id), 32'h0);
    check("rst.gnt_valid", 32'(gnt_valid), 32'h0);
    rst_n = 1'b1;
    cycle("rst_first", 8'hFF, 1'b1);
    check("rst_first.const", 32'(gnt), 32'h01);
    cycle("rst_hold", 8'hFF, 1'b1);

    // Asynchronous reset mid-grant.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.gnt", 32'(gnt), 32'h0);
    check("async_rst.gnt_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("regrant", 8'hFF, 1'b1);

    // Rotation through all owners without idle gaps.
    for (int g = 0; g < 9; g++) begin
      check("rot.id", 32'(gnt_id), 32'(g % 8));
      check("rot.valid", 32'(gnt_valid), 32'h1);
      cycle("rot_own", 8'hFF, 1'b1);
      cycle("rot_rel", 8'hFF & ~(8'h01 << (g % 8)), 1'b1);
    end
    check("rot.final_id", 32'(gnt_id), 32'h1);

    // Wrap and skip.
    cycle("idle", 8'h00, 1'b1);
    cycle("own5", 8'h20, 1'b1);
    check("own5.id", 32'(gnt_id), 32'h5);
    cycle("wrap", 8'h05, 1'b1);
    check("wrap.id", 32'(gnt_id), 32'h0);
    cycle("skip", 8'h04, 1'b1);
    check("skip.id", 32'(gnt_id), 32'h2);
    cycle("to_idle", 8'h00, 1'b1);
    check("to_idle.id", 32'(gnt_id), 32'h2);
    check("to_idle.valid", 32'(gnt_valid), 32'h0);

    // Long hold by owner 3 with everyone else requesting.
    for (int i = 0; i < 50; i++) begin
      cycle("hold", 8'hFF, 1'b1);
`ifdef HOLD_TIMEOUT_EN
      exp_id = 3 + i / MAX_HOLD;
`else
      exp_id = 3;
`endif
      check("hold.const", 32'(gnt), 32'(8'h01 << exp_id));
    end

    // Enable gating.
    cycle("en_idle", 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle("en_low", 8'h10, 1'b0);
      check("en_low.gnt", 32'(gnt), 32'h0);
    end
    cycle("en_high", 8'h10, 1'b1);
    check("en_high.gnt", 32'(gnt), 32'h10);
    cycle("en_drop", 8'h12, 1'b0);
    check("en_drop.gnt", 32'(gnt), 32'h10);
    cycle("en_rel", 8'h02, 1'b0);
    check("en_rel.gnt", 32'(gnt), 32'h0);
    check("en_rel.id", 32'(gnt_id), 32'h4);
    cycle("en_rel2", 8'h02, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      e = ($urandom_range(0, 7) != 0);
      cycle("rand", r, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one 8-to-3 encoded resource slot among 8 requesters.
- Issues a one-hot grant plus its 3-bit encoded index, which feeds the shared datapath select.
- Grant is held while the owner keeps its request high.
- Sits in front of any shared resource that today is driven by a plain priority encoder, replacing fixed priority with fair rotation.

Parameters:
- N, 8, number of requesters (block is verified at 8 only).
- IDW, 3, encoded index width; must equal clog2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles when HOLD_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low blocks new grants only.
- req  input  N  request vector, one bit per requester, level-sensitive.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_id  output  IDW  encoded index of the current or last grant.
- gnt_valid  output  1  high while any gnt bit is high (OR of gnt).

Behaviour:
- Reset (async, rst_n low): gnt=0, gnt_id=0, gnt_valid=0, pointer ptr=0, state IDLE, hold_cnt=0. Takes effect immediately, including mid-grant; operation resumes on the first rising edge after rst_n is released.
- Priority search: starting at index ptr, scan upward modulo N (7 wraps to 0). The first set req bit wins.
- Two states, IDLE and GRANT. All outputs are registered, so a grant appears 1 cycle after the req edge that caused it.
- IDLE:
  - If en=1 and req!=0, the next edge enters GRANT: gnt=onehot(winner), gnt_id=winner, gnt_valid=1.
  - Otherwise stay in IDLE with all outputs unchanged (gnt_id keeps its last value).
- GRANT, req[gnt_id]=1: hold the grant. Other requests are ignored; en is ignored.
- GRANT, req[gnt_id]=0 (release) at an edge:
  - ptr <= gnt_id+1 mod N.
  - If en=1 and any other req is set, the winner is searched from gnt_id+1 and granted on the same edge. There is no idle cycle between owners.
  - Otherwise go to IDLE: gnt=0, gnt_valid=0, gnt_id holds.
- Simultaneous events:
  - Release plus new requests on the same edge: handled as above.
  - A requester re-raising req on the cycle after its own release gets lowest priority for that search.
- gnt never has more than one bit set, and gnt_valid equals |gnt in every cycle.
- Requests are not latched: a req pulse that drops before it is granted is lost.
- en=0 while in GRANT: the current owner keeps the grant. On release, the block goes to IDLE even if other requests are pending.

Optional Feature:
- Macro: HOLD_TIMEOUT_EN.
- Defined:
  - An 8-bit hold_cnt clears on every new grant and increments each GRANT cycle.
  - When hold_cnt = MAX_HOLD-1, req[gnt_id] is still 1, en=1 and another req is set, the next edge force-rotates: ptr <= gnt_id+1 and the grant moves to the searched winner.
  - If no other request is pending, the owner keeps the grant and hold_cnt restarts at 0.
- Not defined: no counter logic; a grant lasts until its owner releases it.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF, then release → gnt=8'h01, gnt_id=0 one cycle after the first edge. Reassert rst_n mid-grant → gnt=0, gnt_valid=0 immediately, without waiting for a clock edge.
- Rotation: req=8'hFF constant, each owner drops its req for 1 cycle after 2 cycles of ownership → gnt_id sequence 0,1,2,…,7,0 with no gnt_valid=0 cycle in between.
- Wrap and skip: ptr=6 (after owner 5 releases), req=8'b0000_0101 → gnt_id=0. On release → gnt_id=2. On release with req=0 → IDLE, gnt_id stays 2.
- Hold: req[3] held high for 50 cycles while req=8'hFF → gnt stays 8'h08 for all 50 cycles (macro undefined). Same test with HOLD_TIMEOUT_EN and MAX_HOLD=16 → grant moves to id 4 after exactly 16 cycles.
- Enable: en=0 with req=8'h10 → no grant. Raise en → gnt=8'h10 on the next edge. Drop en during the grant, then release req[4] while req[1]=1 → IDLE, gnt=0.
- Invariant: random req/en for 10k cycles, checked against a reference model → gnt one-hot or zero, gnt_valid==|gnt, and gnt_id matches onehot(gnt) whenever gnt_valid=1.
